uart_apb_tx_completer: RTL

APB3 completer that receives bytes from the APB3 requester stage and serializes them onto a UART line as 8N1 frames. It sits directly downstream of the Renode-driven APB3 requester and upstream of the external `tx` pin. A small TX FIFO absorbs bursts of bus writes. A programmable divider sets the bit period. Status and interrupt outputs let software pace the writes.

---
 rtl/uart_apb_tx_completer_if.sv | 33 +++
 rtl/uart_apb_tx_completer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_tx_completer_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_apb_tx_completer_if
// Purpose  : APB3 bus bundle between the requester stage and the UART TX
//            completer.
// Ports    : paddr, pselx, penable, pwrite, pwdata  (requester -> completer)
//            prdata, pready, pslverr                (completer -> requester)
// Revision : 1.0 - initial release
// ============================================================================
interface uart_apb_tx_completer_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pselx;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output paddr, pselx, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pselx, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface
`default_nettype wire

// File: rtl/uart_apb_tx_completer.sv
`default_nettype none
// ============================================================================
// Module   : uart_apb_tx_completer
// Purpose  : APB3 completer that buffers written bytes in a TX FIFO and
//            serializes them as 8N1 UART frames with a programmable divider.
// Ports    : clk, rst_n (async, active-low)
//            apb   - APB3 slave modport (DATA/STATUS/DIV/CTRL registers)
//            tx_o  - UART serial output, idles high
//            irq_o - level interrupt: FIFO empty and IRQ_EN set
// Revision : 1.0 - initial release
// ============================================================================
module uart_apb_tx_completer #(
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 32,
  parameter int          FIFO_DEPTH = 8,
  parameter int unsigned DIV_RESET  = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  uart_apb_tx_completer_if.slave  apb,
  output logic                    tx_o,
  output logic                    irq_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] c_ptr_one = (PW+1)'(1);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_start = 2'd1;
  localparam logic [1:0] c_data  = 2'd2;
  localparam logic [1:0] c_stop  = 2'd3;

  localparam logic [1:0] c_reg_data   = 2'd0;
  localparam logic [1:0] c_reg_status = 2'd1;
  localparam logic [1:0] c_reg_div    = 2'd2;
  localparam logic [1:0] c_reg_ctrl   = 2'd3;

  logic [PW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0] div_q, div_d;
  logic        en_q, en_d, irq_en_q, irq_en_d;
  logic [1:0]  state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] tick_q, tick_d;
  logic [15:0] period_q, period_d;
  logic [7:0]  mem_q [FIFO_DEPTH];

  logic        w_access, w_wr_acc, w_full, w_empty, w_busy;
  logic        w_flush, w_push, w_pop, w_can_start;
  logic [1:0]  w_sel;
  logic [PW:0] w_count;
  logic [15:0] w_period_eff;
  logic        w_unused;

  assign w_access = apb.pselx & apb.penable;
  assign w_wr_acc = w_access & apb.pwrite;
  assign w_sel    = apb.paddr[3:2];
  assign w_full   = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                    (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign w_empty  = (wr_ptr_q == rd_ptr_q);
  assign w_count  = wr_ptr_q - rd_ptr_q;
  assign w_busy   = (state_q != c_idle);
  // FLUSH wins over a push in the same access; full is judged pre-pop.
  assign w_flush  = w_wr_acc && (w_sel == c_reg_ctrl) && apb.pwdata[1];
  assign w_push   = w_wr_acc && (w_sel == c_reg_data) && !w_full && !w_flush;
  assign w_can_start  = en_q & ~w_empty;
  assign w_period_eff = (div_q == 16'd0) ? 16'd1 : div_q;
  assign w_unused = ^{apb.paddr[ADDR_WIDTH-1:4], apb.paddr[1:0],
                      apb.pwdata[DATA_WIDTH-1:16]};

  // APB response: zero wait states, outputs gated to the access phase.
  assign apb.pready  = w_access;
  assign apb.pslverr = w_wr_acc && (w_sel == c_reg_data) && w_full;

  always_comb begin
    apb.prdata = '0;
    if (w_access && !apb.pwrite) begin
      case (w_sel)
        c_reg_status: apb.prdata = {{(DATA_WIDTH-9){1'b0}}, 5'(w_count),
                                    1'b0, w_busy, w_empty, w_full};
        c_reg_div:    apb.prdata = {{(DATA_WIDTH-16){1'b0}}, div_q};
        c_reg_ctrl:   apb.prdata = {{(DATA_WIDTH-3){1'b0}}, irq_en_q, 1'b0, en_q};
        default:      apb.prdata = '0;
      endcase
    end
  end

  always_comb begin
    div_d    = div_q;
    en_d     = en_q;
    irq_en_d = irq_en_q;
    if (w_wr_acc && (w_sel == c_reg_div)) div_d = apb.pwdata[15:0];
    if (w_wr_acc && (w_sel == c_reg_ctrl)) begin
      en_d     = apb.pwdata[0];
      irq_en_d = apb.pwdata[2];
    end
  end

  // Serializer: each bit lasts period_q cycles, counted down to 0.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tick_d    = tick_q;
    period_d  = period_q;
    w_pop     = 1'b0;
    case (state_q)
      c_idle: begin
        if (w_can_start) begin
          w_pop    = 1'b1;
          shift_d  = mem_q[rd_ptr_q[PW-1:0]];
          period_d = w_period_eff;
          tick_d   = w_period_eff - 16'd1;
          state_d  = c_start;
        end
      end
      c_start: begin
        if (tick_q == 16'd0) begin
          state_d   = c_data;
          bit_cnt_d = 3'd0;
          tick_d    = period_q - 16'd1;
        end else begin
          tick_d = tick_q - 16'd1;
        end
      end
      c_data: begin
        if (tick_q == 16'd0) begin
          shift_d = {1'b0, shift_q[7:1]};
          tick_d  = period_q - 16'd1;
          if (bit_cnt_q == 3'd7) state_d = c_stop;
          else                   bit_cnt_d = bit_cnt_q + 3'd1;
        end else begin
          tick_d = tick_q - 16'd1;
        end
      end
      c_stop: begin
        if (tick_q == 16'd0) begin
          if (w_can_start) begin
            // Chain straight into the next start bit with no idle gap.
            w_pop    = 1'b1;
            shift_d  = mem_q[rd_ptr_q[PW-1:0]];
            period_d = w_period_eff;
            tick_d   = w_period_eff - 16'd1;
            state_d  = c_start;
          end else begin
            state_d = c_idle;
          end
        end else begin
          tick_d = tick_q - 16'd1;
        end
      end
      default: state_d = c_idle;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + c_ptr_one;
      if (w_pop)  rd_ptr_d = rd_ptr_q + c_ptr_one;
    end
  end

  always_comb begin
    case (state_q)
      c_start: tx_o = 1'b0;
      c_data:  tx_o = shift_q[0];
      default: tx_o = 1'b1;
    endcase
  end

  assign irq_o = w_empty & irq_en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      div_q     <= 16'(DIV_RESET);
      en_q      <= 1'b1;
      irq_en_q  <= 1'b0;
      state_q   <= c_idle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tick_q    <= '0;
      period_q  <= 16'd1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      div_q     <= div_d;
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tick_q    <= tick_d;
      period_q  <= period_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q[PW-1:0]] <= apb.pwdata[7:0];
  end

endmodule
`default_nettype wire
